// File: rtl/ula_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM encoding, flag bit indices.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned FLG_C = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_V = 0;

  // Assemble the status nibble in {C, Z, Nf, V} order.
  function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                            input logic n, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_C] = c;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/ula_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, N cycles after start.
module ula_mul_seq #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_c_o,
  output logic [2*N-1:0] prod_c_o
);

  localparam int unsigned CW = $clog2(N);

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic [2*N-1:0] sum_c;
  logic           last_c;

  // Accumulate one partial product per busy cycle; the final sum is exposed combinationally.
  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    sum_c    = prod_q + (mplier_q[0] ? mcand_q : '0);
    last_c   = busy_q && (cnt_q == CW'(N-1));
    if (start_i) begin
      mcand_d  = {{N{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      prod_d   = sum_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_c) busy_d = 1'b0;
    end
  end

  assign done_c_o = last_c;
  assign prod_c_o = sum_c;

  // Sequencer state; reset aborts any multiply in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Sequential N-bit ALU with valid/ready handshake and {C,Z,Nf,V} flags.
// Define ULA_SEQ_MUL_EN to build the multi-cycle multiplier for opcode 110;
// otherwise opcode 110 completes as an unsupported op (s=0, C=1).
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic [3:0]   flag
);

  localparam int unsigned SHW = $clog2(N);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic [N-1:0] s_q, s_d;
  logic [3:0]   flag_q, flag_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  logic [N-1:0]   ex_s_c;
  logic           ex_cy_c, ex_v_c;
  logic [N:0]     add_c, sub_c;
  logic [2*N-1:0] shl_c;
  logic           mul_start_c;

`ifdef ULA_SEQ_MUL_EN
  logic           mul_done_c;
  logic [2*N-1:0] mul_prod_c;

  ula_mul_seq #(.N(N)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start_c),
    .a_i      (a),
    .b_i      (b),
    .done_c_o (mul_done_c),
    .prod_c_o (mul_prod_c)
  );
`endif

  // Single-cycle datapath, one mux on the latched opcode.
  always_comb begin
    add_c   = {1'b0, a_q} + {1'b0, b_q};
    sub_c   = {1'b0, a_q} - {1'b0, b_q};
    shl_c   = {{N{1'b0}}, a_q} << b_q[SHW-1:0];
    ex_s_c  = '0;
    ex_cy_c = 1'b0;
    ex_v_c  = 1'b0;
    case (op_q)
      OP_ADD: begin
        ex_s_c  = add_c[N-1:0];
        ex_cy_c = add_c[N];
        ex_v_c  = (a_q[N-1] == b_q[N-1]) && (add_c[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        ex_s_c  = sub_c[N-1:0];
        ex_cy_c = sub_c[N];
        ex_v_c  = (a_q[N-1] != b_q[N-1]) && (sub_c[N-1] != a_q[N-1]);
      end
      OP_XOR: ex_s_c = a_q ^ b_q;
      OP_NOT: ex_s_c = ~a_q;
      OP_AND: ex_s_c = a_q & b_q;
      OP_OR:  ex_s_c = a_q | b_q;
      OP_SHL: begin
        ex_s_c  = shl_c[N-1:0];
        ex_cy_c = |shl_c[2*N-1:N];
      end
      default: begin
        // Opcode 110 only lands here when the multiplier is not built.
        ex_s_c  = '0;
        ex_cy_c = 1'b1;
      end
    endcase
  end

  // Next-state and register-input logic for the handshake FSM.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    s_d         = s_q;
    flag_d      = flag_q;
    mul_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = opcode;
          state_d = ST_EXEC;
`ifdef ULA_SEQ_MUL_EN
          if (opcode == OP_MUL) begin
            mul_start_c = 1'b1;
            state_d     = ST_MUL;
          end
`endif
        end
      end
      ST_EXEC: begin
        s_d     = ex_s_c;
        flag_d  = pack_flags(ex_cy_c, ex_s_c == '0, ex_s_c[N-1], ex_v_c);
        state_d = ST_DONE;
      end
      ST_MUL: begin
`ifdef ULA_SEQ_MUL_EN
        if (mul_done_c) begin
          s_d     = mul_prod_c[N-1:0];
          flag_d  = pack_flags(|mul_prod_c[2*N-1:N], mul_prod_c[N-1:0] == '0,
                               mul_prod_c[N-1], 1'b0);
          state_d = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      s_q         <= '0;
      flag_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      s_q         <= s_d;
      flag_q      <= flag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign flag      = flag_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed-vector bench for ula_seq (N=8); follows ULA_SEQ_MUL_EN for opcode 110 expectations.
module tb_ula_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic [3:0] flag;

  int n_checks;
  int n_errors;

  ula_seq #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .flag      (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one op, measure latency, check result, optionally stall out_ready, then accept.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input int exp_lat, input logic [7:0] exp_s,
                        input logic [3:0] exp_f, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".rdy_in"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    opcode   = op;
    a        = va;
    b        = vb;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'hFF;
    b        = 8'hFF;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".s"}, 32'(s), 32'(exp_s));
    check({tag, ".flag"}, 32'(flag), 32'(exp_f));
    check({tag, ".busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      opcode   = 3'(i);
      a        = 8'(i * 37);
      b        = 8'(i + 1);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_s"}, 32'(s), 32'(exp_s));
      check({tag, ".hold_flag"}, 32'(flag), 32'(exp_f));
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
    check({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.s", 32'(s), 32'd0);
    check("rst.flag", 32'(flag), 32'd0);
    rst = 1'b0;

    run_op("add_carry", 3'b000, 8'd200, 8'd100, 2, 8'd44, 4'b1000, 0);
    run_op("add_ovf", 3'b000, 8'h7F, 8'h01, 2, 8'h80, 4'b0011, 0);
    run_op("sub_borrow", 3'b001, 8'd3, 8'd5, 2, 8'd254, 4'b1010, 0);
    run_op("sub_ovf", 3'b001, 8'h80, 8'h01, 2, 8'h7F, 4'b0001, 0);
    run_op("xor_zero", 3'b010, 8'h5A, 8'h5A, 2, 8'h00, 4'b0100, 0);
    run_op("not", 3'b011, 8'h0F, 8'h33, 2, 8'hF0, 4'b0010, 0);
    run_op("and", 3'b100, 8'hF0, 8'h3C, 2, 8'h30, 4'b0000, 0);
    run_op("or", 3'b101, 8'h41, 8'h12, 2, 8'h53, 4'b0000, 0);
    run_op("shl_out", 3'b111, 8'h81, 8'd1, 2, 8'h02, 4'b1000, 0);
    run_op("shl_zero", 3'b111, 8'h81, 8'd0, 2, 8'h81, 4'b0010, 0);
    run_op("backpress", 3'b000, 8'd1, 8'd2, 2, 8'd3, 4'b0000, 5);
`ifdef ULA_SEQ_MUL_EN
    run_op("mul_hi", 3'b110, 8'd20, 8'd15, 9, 8'h2C, 4'b1000, 0);
    run_op("mul_lo", 3'b110, 8'd3, 8'd4, 9, 8'd12, 4'b0000, 0);
`else
    run_op("mul_off", 3'b110, 8'd20, 8'd15, 2, 8'h00, 4'b1100, 0);
`endif

    // Reset in the middle of a multiply (or its unsupported-op completion).
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 3'b110;
    a        = 8'd5;
    b        = 8'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.s", 32'(s), 32'd0);
    check("midrst.flag", 32'(flag), 32'd0);

    run_op("post_rst", 3'b001, 8'd10, 8'd10, 2, 8'd0, 4'b0100, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
